// File: rtl/systolic_feeder.sv
// systolic_feeder: upstream stage of the PE array.
//   Accepts one weight vector and one activation vector per beat (valid/ready),
//   and drives them to the array with diagonal skew: lane k arrives k cycles
//   later than lane 0. Pulses fire at the start of a pass. After len beats it
//   shifts in zeros until the last products have settled, then pulses done.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   start, len          begin a pass of len beats (sampled only when idle)
//   in_valid, in_ready  beat handshake
//   in_w, in_a          weight / activation vectors, lane k = bits [8k:8k+7]
//   out_w, out_a        skewed vectors to the array's in_w_port / in_a_port
//   fire, busy, done    pass start pulse, pass in progress, pass complete pulse

// One skew line: DEPTH registers, shifted every cycle.
module systolic_feeder_lane #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] d,
  output logic [7:0] q
);
  logic [DEPTH-1:0][7:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

module systolic_feeder #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int LEN_W       = 16,
  parameter int DRAIN_EXTRA = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:8*ROWS-1] in_w,
  input  logic [0:8*COLS-1] in_a,
  output logic [0:8*ROWS-1] out_w,
  output logic [0:8*COLS-1] out_a,
  output logic              fire,
  output logic              busy,
  output logic              done
);
  localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
  // Cycles for the last skewed beat to cross the array plus PE latency.
  localparam int D      = (ROWS-1) + (COLS-1) + (MAX_RC-1) + DRAIN_EXTRA;
  localparam int DC_W   = (D < 2) ? 1 : $clog2(D+1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state, nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [DC_W-1:0]   drain_cnt;
  logic              launch;
  logic              accept;
  logic [0:8*ROWS-1] beat_w;
  logic [0:8*COLS-1] beat_a;

  assign launch = (state == S_IDLE) && start && (len != '0);
  assign accept = in_ready && in_valid;
  // Non-accepted cycles feed zeros: MAC-neutral bubbles and flush data.
  assign beat_w = accept ? in_w : '0;
  assign beat_a = accept ? in_a : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:   if (launch) nxt = S_STREAM;
      S_STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // cnt stops at len-1, so len = all-ones never wraps.
        if (in_valid && (cnt == len_q - LEN_W'(1))) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DC_W'(D-1)) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fire      <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      fire <= launch;
      if (launch) begin
        len_q <= len;
        cnt   <= '0;
      end else if (accept) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DC_W'(1);
      else                  drain_cnt <= '0;
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_w
    systolic_feeder_lane #(.DEPTH(k+1)) u_lane (
      .clk (clk),
      .rstn(rstn),
      .d   (beat_w[8*k +: 8]),
      .q   (out_w[8*k +: 8])
    );
  end

  for (genvar k = 0; k < COLS; k++) begin : g_a
    systolic_feeder_lane #(.DEPTH(k+1)) u_lane (
      .clk (clk),
      .rstn(rstn),
      .d   (beat_a[8*k +: 8]),
      .q   (out_a[8*k +: 8])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: self-checking bench for systolic_feeder (4x4, D=10).
//   A pass-level reference model predicts every output every cycle; a table
//   and hand-written sequences pin down the documented corner cases.
module tb_systolic_feeder;
  localparam int ROWS = 4, COLS = 4, LEN_W = 16, DE = 1;
  localparam int D = 10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [0:8*ROWS-1] in_w = '0;
  logic [0:8*COLS-1] in_a = '0;
  logic [0:8*ROWS-1] out_w;
  logic [0:8*COLS-1] out_a;
  logic              fire, busy, done;

  systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W), .DRAIN_EXTRA(DE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_w(in_w), .in_a(in_a), .out_w(out_w), .out_a(out_a),
    .fire(fire), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: a pass is "beats still owed" plus the cycle done is due.
  bit          m_active;
  int          m_left, m_done_cyc, m_fire_cyc;
  logic [0:31] hw[4], ha[4];   // hw[j] = vector fed to the skew lines j+1 cycles ago

  logic [0:31] s_w, s_a;
  logic        s_fire, s_busy, s_done, s_rdy;

  typedef struct {
    bit          st; int ln; bit v;
    logic [31:0] w;  logic [31:0] ew;
    bit          efire, ebusy, edone, erdy;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_left = 0; m_done_cyc = -1; m_fire_cyc = -1;
    for (int i = 0; i < 4; i++) begin hw[i] = '0; ha[i] = '0; end
  endtask

  function automatic bit exp_rdy();
    return m_active && (m_left > 0);
  endfunction

  task automatic check_model();
    logic [0:31] ew, ea;
    for (int k = 0; k < 4; k++) begin
      ew[8*k +: 8] = hw[k][8*k +: 8];
      ea[8*k +: 8] = ha[k][8*k +: 8];
    end
    chk("m_out_w", s_w, ew);
    chk("m_out_a", s_a, ea);
    chk("m_ready", 32'(s_rdy), 32'(exp_rdy()));
    chk("m_busy",  32'(s_busy), 32'(m_active && (m_left > 0 || cyc < m_done_cyc)));
    chk("m_done",  32'(s_done), 32'(m_active && m_left == 0 && cyc == m_done_cyc));
    chk("m_fire",  32'(s_fire), 32'(cyc == m_fire_cyc));
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, step to edge+1.
  task automatic cycle(input bit st, input int ln, input bit v,
                       input logic [31:0] w, input logic [31:0] a);
    bit acc, done_now, idle_now;
    start = st; len = ln[LEN_W-1:0]; in_valid = v; in_w = w; in_a = a;
    if (!rstn) model_reset();
    @(negedge clk);
    s_w = out_w; s_a = out_a; s_fire = fire; s_busy = busy; s_done = done; s_rdy = in_ready;
    check_model();
    if (rstn) begin
      acc      = exp_rdy() && v;
      done_now = m_active && m_left == 0 && cyc == m_done_cyc;
      idle_now = !m_active;
      for (int i = 3; i > 0; i--) begin hw[i] = hw[i-1]; ha[i] = ha[i-1]; end
      hw[0] = acc ? w : '0;
      ha[0] = acc ? a : '0;
      if (acc) begin
        m_left--;
        if (m_left == 0) m_done_cyc = cyc + D + 1;
      end
      if (done_now) m_active = 0;
      if (idle_now && st && ln[LEN_W-1:0] != 0) begin
        m_active = 1; m_left = ln[LEN_W-1:0]; m_fire_cyc = cyc + 1; m_done_cyc = -1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0);
  endtask

  // Runs idle cycles until done; dc is the cycle done was seen, -1 on timeout.
  task automatic run_until_done(input string nm, output int dc);
    int c;
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      c = cyc;
      cycle(0, 0, 0, '0, '0);
      if (s_done) begin dc = c; break; end
    end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL %s_timeout cyc=%0d actual=no done required=done", nm, cyc); end
  endtask

  initial begin
    int c0, dc, t;
    logic [31:0] v0, v1, v2;
    model_reset();

    // 1: reset held with random inputs
    for (int i = 0; i < 4; i++) cycle(1, $urandom_range(1, 5), 1, $urandom, $urandom);
    chk("rst_out_w", s_w, 0);
    chk("rst_out_a", s_a, 0);
    chk("rst_ctl", {28'd0, s_fire, s_busy, s_done, s_rdy}, 0);
    rstn = 1'b1;
    idle(3);
    chk("post_rst_ready", 32'(s_rdy), 0);

    // 2: table, len=1 single beat
    tbl[0] = '{1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 32'h01020304, 32'h0, 1, 1, 0, 1};
    tbl[2] = '{0, 0, 0, 32'h0, 32'h01000000, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 32'h0, 32'h00020000, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 32'h0, 32'h00000300, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 32'h0, 32'h00000004, 0, 1, 0, 0};
    for (int i = 6; i < 12; i++) tbl[i] = '{0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].st, tbl[i].ln, tbl[i].v, tbl[i].w, 32'h0);
      chk($sformatf("t2_w_c%0d", i), s_w, tbl[i].ew);
      chk($sformatf("t2_ctl_c%0d", i), {28'd0, s_fire, s_busy, s_done, s_rdy},
          {28'd0, tbl[i].efire, tbl[i].ebusy, tbl[i].edone, tbl[i].erdy});
    end

    // 3: len=3 with a bubble
    v0 = 32'h11121314; v1 = 32'h21222324; v2 = 32'h31323334;
    cycle(1, 3, 0, '0, '0);
    cycle(0, 0, 1, v0, 32'h0);
    cycle(0, 0, 0, 32'hdeadbeef, 32'h0); chk("t3_l0_v0", 32'(s_w[0:7]), 32'h11);
    cycle(0, 0, 1, v1, 32'h0);           chk("t3_l0_bub", 32'(s_w[0:7]), 32'h00);
    t = cyc;
    cycle(0, 0, 1, v2, 32'h0);           chk("t3_l0_v1", 32'(s_w[0:7]), 32'h21);
    cycle(0, 0, 0, '0, '0);              chk("t3_l0_v2", 32'(s_w[0:7]), 32'h31);
    chk("t3_drain_rdy", 32'(s_rdy), 0);
    run_until_done("t3", dc);
    chk("t3_done_lat", 32'(dc - t), 32'(D + 1));
    idle(2);

    // 4: ignored starts
    cycle(1, 0, 1, $urandom, $urandom);
    cycle(1, 0, 0, '0, '0);
    chk("t4_len0_nofire", {30'd0, s_fire, s_busy}, 0);
    cycle(1, 2, 1, $urandom, $urandom);
    c0 = cyc;
    cycle(1, 7, 1, $urandom, $urandom);
    t = cyc;
    cycle(1, 7, 1, $urandom, $urandom);
    for (int i = 0; i < 4; i++) cycle(1, 5, 0, '0, '0);
    dc = -1;
    for (int i = 0; i < 20; i++) begin
      int c; c = cyc;
      cycle(i < 8, 5, 0, '0, '0);
      if (s_done) begin dc = c; break; end
    end
    chk("t4_done_lat", 32'(dc - t), 32'(D + 1));
    idle(3);
    chk("t4_no_extra", {30'd0, s_fire, s_done}, 0);

    // 5: async reset mid-drain, then a clean pass
    cycle(1, 1, 0, '0, '0);
    cycle(0, 0, 1, $urandom, $urandom);
    idle(3);
    rstn = 1'b0;
    #1;
    chk("t5_async_w", out_w, 0);
    chk("t5_async_a", out_a, 0);
    chk("t5_async_ctl", {28'd0, fire, busy, done, in_ready}, 0);
    cycle(0, 0, 0, '0, '0);
    cycle(1, 3, 1, $urandom, $urandom);
    rstn = 1'b1;
    idle(12);
    chk("t5_no_done", 32'(s_done), 0);
    cycle(1, 2, 0, '0, '0);
    cycle(0, 0, 1, $urandom, $urandom);
    cycle(0, 0, 1, $urandom, $urandom);
    run_until_done("t5", dc);
    idle(2);

    // 6: activation skew
    cycle(1, 1, 0, '0, '0);
    t = cyc;
    cycle(0, 0, 1, 32'h0, 32'hAABBCCDD);
    cycle(0, 0, 0, '0, '0); chk("t6_a0", s_a, 32'hAA000000);
    cycle(0, 0, 0, '0, '0); chk("t6_a1", s_a, 32'h00BB0000);
    cycle(0, 0, 0, '0, '0); chk("t6_a2", s_a, 32'h0000CC00);
    cycle(0, 0, 0, '0, '0); chk("t6_a3", s_a, 32'h000000DD);
    run_until_done("t6", dc);
    chk("t6_done_lat", 32'(dc - t), 32'(D + 1));

    // random traffic against the model
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 6), $urandom_range(0, 2) != 0,
            $urandom, $urandom);
    idle(30);

    // maximum length: counter must not wrap
    cycle(1, 65535, 0, '0, '0);
    for (int i = 0; i < 65535; i++) cycle(0, 0, 1, $urandom, $urandom);
    chk("long_drain_rdy", 32'(s_rdy), 1);
    cycle(0, 0, 0, '0, '0);
    chk("long_in_drain", {30'd0, s_busy, s_rdy}, 32'h2);
    run_until_done("long", dc);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
